// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer write arbiter.
// Optional build macro: FB_CLEAR_ON_RESET_EN (see fb_write_arbiter).
package fb_arb_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] GS_PLAY = 3'b010;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    REQ_BLUE = 1'b0,
    REQ_RED  = 1'b1
  } req_e;

endpackage

// File: rtl/fb_arb_if.sv
// Bus bundle between the trail writers / game FSM and the
// frame-buffer write arbiter, plus the SRAM write port it drives.
interface fb_arb_if
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [2:0]        Game_State;
  logic              vga_busy;
  logic              clear_start;

  logic              blue_req;
  logic [ADDR_W-1:0] blue_addr;
  logic [DATA_W-1:0] blue_data;
  logic              blue_gnt;

  logic              red_req;
  logic [ADDR_W-1:0] red_addr;
  logic [DATA_W-1:0] red_data;
  logic              red_gnt;

  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;

  logic              clear_busy;
  logic              clear_done;

  modport master (
    output Game_State,
    output vga_busy,
    output clear_start,
    output blue_req,
    output blue_addr,
    output blue_data,
    input  blue_gnt,
    output red_req,
    output red_addr,
    output red_data,
    input  red_gnt,
    input  sram_we,
    input  sram_addr,
    input  sram_wdata,
    input  clear_busy,
    input  clear_done
  );

  modport slave (
    input  Game_State,
    input  vga_busy,
    input  clear_start,
    input  blue_req,
    input  blue_addr,
    input  blue_data,
    output blue_gnt,
    input  red_req,
    input  red_addr,
    input  red_data,
    output red_gnt,
    output sram_we,
    output sram_addr,
    output sram_wdata,
    output clear_busy,
    output clear_done
  );

endinterface

// File: rtl/fb_write_arbiter_clear_counter.sv
// Screen-clear address counter: stall, restart, last-word detect
// and the one-cycle done pulse after the final word.
module fb_clear_counter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int FB_WORDS = 307200
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              restart_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              fin_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FB_WORDS - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              fin_q, fin_d;
  logic              done_q, done_d;
  logic              at_last;

  assign at_last = (cnt_q == LAST);

  // fin marks the cycle in which the last word is on the bus
  always_comb begin
    cnt_d  = cnt_q;
    fin_d  = 1'b0;
    done_d = fin_q & ~restart_i;
    if (restart_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      fin_d = at_last;
      if (!at_last) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      fin_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fin_q  <= fin_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign fin_o  = fin_q;
  assign done_o = done_q;

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer SRAM write-port arbiter: blue/red trails + clear.
// Build macro FB_CLEAR_ON_RESET_EN: start a clear on reset release.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                FB_WORDS    = 307200,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic    Clk,
  input  logic    Reset_n,
  fb_arb_if.slave bus
);

`ifdef FB_CLEAR_ON_RESET_EN
  localparam state_e ST_RST = CLEAR;
`else
  localparam state_e ST_RST = ARB;
`endif

  state_e            state_q, state_d;
  req_e              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              bgnt_q, bgnt_d;
  logic              rgnt_q, rgnt_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_fin;
  logic              clr_done;
  logic              clr_step;

  logic bv, rv;
  logic grant_ok;
  logic pick_blue, pick_red;

  // a writer granted last cycle sits out one decision
  assign bv = bus.blue_req & ~bgnt_q;
  assign rv = bus.red_req  & ~rgnt_q;

  assign grant_ok = (bus.Game_State == GS_PLAY)
                  & ~bus.vga_busy
                  & ~bus.clear_start;

  assign pick_blue = grant_ok & bv
                   & (~rv | (last_q == REQ_RED));
  assign pick_red  = grant_ok & rv & ~pick_blue;

  assign clr_step = (state_q == CLEAR)
                  & ~bus.vga_busy
                  & ~clr_fin
                  & ~bus.clear_start;

  fb_clear_counter #(
    .ADDR_W   (ADDR_W),
    .FB_WORDS (FB_WORDS)
  ) u_clr (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .restart_i (bus.clear_start),
    .step_i    (clr_step),
    .cnt_o     (clr_cnt),
    .fin_o     (clr_fin),
    .done_o    (clr_done)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    bgnt_d  = 1'b0;
    rgnt_d  = 1'b0;
    unique case (state_q)
      ARB: begin
        if (bus.clear_start) begin
          state_d = CLEAR;
        end
        unique case (1'b1)
          pick_blue: begin
            we_d    = 1'b1;
            bgnt_d  = 1'b1;
            last_d  = REQ_BLUE;
            addr_d  = bus.blue_addr;
            wdata_d = bus.blue_data;
          end
          pick_red: begin
            we_d    = 1'b1;
            rgnt_d  = 1'b1;
            last_d  = REQ_RED;
            addr_d  = bus.red_addr;
            wdata_d = bus.red_data;
          end
          default: ;
        endcase
      end
      CLEAR: begin
        if (!bus.clear_start && clr_fin) begin
          state_d = ARB;
        end else if (clr_step) begin
          we_d    = 1'b1;
          addr_d  = clr_cnt;
          wdata_d = CLEAR_VALUE;
        end
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_RST;
      last_q  <= REQ_RED;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bgnt_q  <= 1'b0;
      rgnt_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bgnt_q  <= bgnt_d;
      rgnt_q  <= rgnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sram_we    = we_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.blue_gnt   = bgnt_q;
  assign bus.red_gnt    = rgnt_q;
  assign bus.clear_busy = busy_q;
  assign bus.clear_done = clr_done;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter with a small FB_WORDS.
// Reference model predicts every write / done event per edge.
module tb_fb_write_arbiter;

  localparam int AW  = 19;
  localparam int DW  = 16;
  localparam int FBW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_write_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .FB_WORDS    (FBW),
    .CLEAR_VALUE (16'h0000)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int          t;
    bit          bg;
    bit          rg;
    bit          cl;
    bit          dn;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ev_t;

  ev_t sb[$];
  bit  exp_busy[int];
  int  ecnt   = 0;
  int  errs   = 0;
  int  checks = 0;

  // model state: clearing flag, next clear index, last word sent,
  // last winner (0 blue / 1 red), who was granted at the last edge
  bit m_clr, m_fin, m_gb, m_gr;
  int m_idx, m_last;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (edge %0d)",
               nm, act, exp, ecnt);
    end
  endtask

  task automatic model_reset();
`ifdef FB_CLEAR_ON_RESET_EN
    m_clr = 1'b1;
`else
    m_clr = 1'b0;
`endif
    m_fin  = 1'b0;
    m_idx  = 0;
    m_last = 1;
    m_gb   = 1'b0;
    m_gr   = 1'b0;
  endtask

  // predicts what the edge about to come does with current inputs
  task automatic model_step();
    ev_t e;
    bit  bv, rv;
    int  w;
    e.t  = ecnt + 1;
    e.bg = 0; e.rg = 0; e.cl = 0; e.dn = 0;
    e.a  = '0; e.d = '0;
    bv = bus.blue_req && !m_gb;
    rv = bus.red_req  && !m_gr;
    m_gb = 0;
    m_gr = 0;
    if (bus.clear_start) begin
      m_clr = 1; m_idx = 0; m_fin = 0;
    end else if (m_clr) begin
      if (m_fin) begin
        m_clr = 0; m_fin = 0; e.dn = 1;
      end else if (!bus.vga_busy) begin
        e.cl = 1;
        e.a  = AW'(m_idx);
        e.d  = 16'h0000;
        if (m_idx == FBW - 1) m_fin = 1;
        else m_idx++;
      end
    end else if (bus.Game_State == 3'b010 && !bus.vga_busy
                 && (bv || rv)) begin
      w = (bv && rv) ? 1 - m_last : (bv ? 0 : 1);
      m_last = w;
      if (w == 0) begin
        m_gb = 1; e.bg = 1;
        e.a = bus.blue_addr; e.d = bus.blue_data;
      end else begin
        m_gr = 1; e.rg = 1;
        e.a = bus.red_addr; e.d = bus.red_data;
      end
    end
    exp_busy[e.t] = m_clr;
    if (e.bg || e.rg || e.cl || e.dn) sb.push_back(e);
  endtask

  // monitor: compares DUT outputs with the queued predictions
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].t < ecnt) begin
        chk("missed_event_edge", ecnt, sb[0].t);
        void'(sb.pop_front());
      end
      if (exp_busy.exists(ecnt))
        chk("clear_busy", bus.clear_busy, exp_busy[ecnt]);
      chk("gnt_exclusive", bus.blue_gnt & bus.red_gnt, 0);
      if (bus.sram_we)
        chk("we_one_source",
            int'(bus.blue_gnt) + int'(bus.red_gnt)
            + int'(bus.clear_busy), 1);
      if (bus.sram_we || bus.blue_gnt || bus.red_gnt
          || bus.clear_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_output",
              {bus.sram_we, bus.blue_gnt, bus.red_gnt,
               bus.clear_done}, 0);
        end else if (sb[0].t != ecnt) begin
          chk("early_event_edge", ecnt, sb[0].t);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("sram_we", bus.sram_we, e.bg | e.rg | e.cl);
          chk("blue_gnt", bus.blue_gnt, e.bg);
          chk("red_gnt", bus.red_gnt, e.rg);
          chk("clear_done", bus.clear_done, e.dn);
          if (bus.sram_we) begin
            chk("sram_addr", bus.sram_addr, e.a);
            chk("sram_wdata", bus.sram_wdata, e.d);
          end
        end
      end
    end
  end

  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(int hold);
    rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        {bus.sram_we, bus.blue_gnt, bus.red_gnt,
         bus.clear_busy, bus.clear_done,
         bus.sram_addr, bus.sram_wdata}, 0);
    sb.delete();
    exp_busy.delete();
    model_reset();
    repeat (hold) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // writer protocol: may change its request only once granted
  task automatic upd_reqs(int p_new);
    if (m_gb || !bus.blue_req) begin
      bus.blue_req  = ($urandom_range(99) < p_new);
      bus.blue_addr = AW'($urandom);
      bus.blue_data = DW'($urandom);
    end
    if (m_gr || !bus.red_req) begin
      bus.red_req  = ($urandom_range(99) < p_new);
      bus.red_addr = AW'($urandom);
      bus.red_data = DW'($urandom);
    end
  endtask

  initial begin
    bus.Game_State  = 3'b010;
    bus.vga_busy    = 1'b0;
    bus.clear_start = 1'b0;
    bus.blue_req    = 1'b1;
    bus.blue_addr   = 19'h00100;
    bus.blue_data   = 16'h00F0;
    bus.red_req     = 1'b0;
    bus.red_addr    = '0;
    bus.red_data    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs_init",
        {bus.sram_we, bus.blue_gnt, bus.red_gnt,
         bus.clear_busy, bus.clear_done}, 0);
    rst_n = 1'b1;

    // first grant, then blue masked for one cycle
    repeat (14) tick();
    bus.blue_req = 1'b0;
    tick();

    // both held: strict alternation
    bus.blue_req  = 1'b1;
    bus.blue_addr = 19'h00AAA;
    bus.blue_data = 16'h1111;
    bus.red_req   = 1'b1;
    bus.red_addr  = 19'h05555;
    bus.red_data  = 16'h2222;
    repeat (6) tick();
    bus.blue_req = 1'b0;
    bus.red_req  = 1'b0;
    repeat (2) tick();

    // vga_busy stalls a pending red request
    bus.red_req  = 1'b1;
    bus.red_addr = 19'h12345;
    bus.red_data = 16'hBEEF;
    bus.vga_busy = 1'b1;
    repeat (3) tick();
    bus.vga_busy = 1'b0;
    tick();
    bus.red_req = 1'b0;
    repeat (2) tick();

    // not in play: no grant until Game_State returns to play
    bus.Game_State = 3'b000;
    bus.red_req    = 1'b1;
    bus.red_addr   = 19'h7FFFF;
    bus.red_data   = 16'hFFFF;
    repeat (3) tick();
    bus.Game_State = 3'b010;
    tick();
    bus.red_req = 1'b0;
    repeat (2) tick();

    // full clear with blue held throughout
    bus.blue_req    = 1'b1;
    bus.blue_addr   = 19'h00042;
    bus.blue_data   = 16'hCAFE;
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    for (int i = 0; i < 40 && m_clr; i++) tick();
    repeat (3) tick();
    bus.blue_req = 1'b0;
    tick();

    // restart mid-clear, with vga stalls sprinkled in
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    repeat (3) tick();
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    for (int i = 0; i < 40 && m_clr; i++) begin
      bus.vga_busy = (i % 3 == 1);
      tick();
    end
    bus.vga_busy = 1'b0;
    repeat (2) tick();

    // reset asserted mid-clear at counter 3
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    for (int i = 0; i < 20 && !(m_clr && m_idx == 3); i++)
      tick();
    chk("reached_cnt3", m_idx, 3);
    do_reset(2);
    repeat (14) tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.vga_busy    = ($urandom_range(3) == 0);
      bus.Game_State  = ($urandom_range(9) == 0)
                      ? 3'($urandom_range(7)) : 3'b010;
      bus.clear_start = ($urandom_range(59) == 0);
      upd_reqs(60);
      tick();
    end

    bus.vga_busy    = 1'b0;
    bus.clear_start = 1'b0;
    bus.Game_State  = 3'b010;
    for (int i = 0; i < 30; i++) begin
      upd_reqs(0);
      tick();
    end
    repeat (3) tick();
    chk("leftover_events", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Owns the single frame-buffer SRAM write port.
- Shares that port between the blue and red trail writers.
- Runs a built-in screen-clear sequencer that zero-fills the buffer between rounds.
- Yields every cycle the VGA scan-out reserves the SRAM (vga_busy), so display reads are never disturbed.

Parameters:
ADDR_W, 19, SRAM word-address width
DATA_W, 16, SRAM data width
FB_WORDS, 307200, number of words zeroed by a clear (addresses 0..FB_WORDS-1)
CLEAR_VALUE, 16'h0000, data written during clear

Ports:
Clk  in  1  system clock, 50 MHz
Reset_n  in  1  asynchronous, active-low reset
Game_State  in  3  game FSM state; 3'b010 = play
vga_busy  in  1  high = SRAM slot reserved for scan-out; no write may issue
clear_start  in  1  one-cycle pulse requesting a full-buffer clear
blue_req  in  1  blue trail write request; level, held until granted
blue_addr  in  ADDR_W  blue write address, stable while blue_req is high
blue_data  in  DATA_W  blue write data, stable while blue_req is high
blue_gnt  out  1  one-cycle pulse; blue write is being performed this cycle
red_req, red_addr, red_data, red_gnt  same as the blue set, for red
sram_we  out  1  write strobe
sram_addr  out  ADDR_W  write address
sram_wdata  out  DATA_W  write data
clear_busy  out  1  high while the clear sequencer is running
clear_done  out  1  one-cycle pulse after the last clear word is written

Behaviour:
- Reset: all outputs are 0 while Reset_n is low. State = ARB, last-winner = red (so blue wins the first tie), clear counter = 0. Assertion takes effect immediately, including mid-clear; after release the clear does not resume.
- Registered outputs: sram_*, *_gnt, clear_busy and clear_done are driven from flops.
- Grant latency: a request sampled at edge k gives gnt=1 with sram_we=1 throughout cycle k+1. sram_addr/sram_wdata carry that requester's addr/data captured at edge k.
- States:
  - ARB:
    - Grants only when Game_State==3'b010 and vga_busy==0; otherwise no grant, and requests simply wait.
    - One requester valid: it wins.
    - Both valid: the requester that did not win last time wins.
    - The requester granted in cycle k+1 is masked from the decision at edge k+1, which gives it one cycle to drop or update its request. Throughput: 1 write/cycle when the two alternate, 1 write per 2 cycles for a single requester.
    - clear_start=1 -> go to CLEAR, counter=0.
  - CLEAR:
    - clear_busy=1.
    - Each edge with vga_busy==0 issues a write of CLEAR_VALUE to the counter address, then counter+1.
    - vga_busy=1 stalls: counter holds, sram_we=0.
    - No trail grants are issued; pending requests stay pending.
    - Write to address FB_WORDS-1 -> next cycle clear_done=1, clear_busy=0, state = ARB.
    - clear_start during CLEAR restarts: counter=0, no clear_done.
- Simultaneous events:
  - clear_start and a trail request at the same edge: clear wins, and the request waits until clear_done.
  - vga_busy has absolute priority over both clear and grants.
- Counter: ADDR_W bits wide, compared against FB_WORDS-1; it never wraps past FB_WORDS.
- Exclusivity: sram_we is never high without exactly one source (blue, red or clear) active. blue_gnt and red_gnt are never high together.

Optional Feature:
- Macro: FB_CLEAR_ON_RESET_EN.
- Defined: on Reset_n release, the state goes directly to CLEAR with counter=0. The buffer is fully zeroed before any grant, and clear_done pulses at the end as usual.
- Undefined: after reset the state is ARB and no clear occurs until clear_start.

Decomposition:
- Package fb_arb_pkg holds:
  - state enum {ARB, CLEAR}
  - requester enum {REQ_BLUE, REQ_RED}
  - GS_PLAY = 3'b010
  - default ADDR_W/DATA_W localparams
- One sub-module: fb_clear_counter (counter, stall, restart, last-word detect, done pulse). The arbiter instantiates it.

Test Plan:
- Reset release with Game_State=3'b010, blue_req=1, blue_addr=19'h00100, blue_data=16'h00F0 -> cycle 2: blue_gnt=1, sram_we=1, sram_addr=19'h00100, sram_wdata=16'h00F0. Then blue is masked for one cycle.
- blue_req and red_req held high together for 6 cycles -> grants alternate blue, red, blue, red…, one per cycle, never both at once.
- vga_busy=1 for 3 cycles during a pending red_req -> no sram_we. red_gnt rises on the cycle after vga_busy falls.
- clear_start with FB_WORDS=8 (bench override) -> writes of 16'h0000 to addresses 0..7. clear_done pulses once in the cycle after address 7. A blue_req held throughout is granted only after clear_done.
- Reset_n pulled low mid-clear at counter=3 -> outputs go to 0 immediately. After release, clear_busy=0 (macro undefined), or a fresh clear starts from address 0 (FB_CLEAR_ON_RESET_EN defined).
- Game_State=3'b000 with red_req=1 -> no grant. Switching to 3'b010 -> red_gnt in the next cycle.
